// File: rtl/weight_load_ctrl.sv
// Runtime weight loader for one layer: filters a header+payload stream by layer number and
// steers each payload word to its neuron's weight-memory write port (1-cycle write latency).
// Accepts one word per cycle; s_ready drops only for the single DONE cycle after a packet.
module weight_load_ctrl #(
    parameter int NUM_NEURONS = 30,
    parameter int WEIGHT_NUM  = 784,
    parameter int LAYER_NO    = 1,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_WIDTH-1:0]  s_data,
    input  logic                   s_last,
    output logic [NUM_NEURONS-1:0] wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SKIP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [NW-1:0]          NRN_LAST = NW'(NUM_NEURONS - 1);
    localparam logic [ADDR_WIDTH-1:0]  W_LAST   = ADDR_WIDTH'(WEIGHT_NUM - 1);
    localparam logic [7:0]             LAYER    = 8'(LAYER_NO);
    localparam logic [NUM_NEURONS-1:0] ONE_HOT0 = NUM_NEURONS'(1);

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [NW-1:0]          nrn_cnt;
    logic [ADDR_WIDTH-1:0]  w_cnt;
    logic                   ready_q;
    logic                   done_q;
    logic                   err_q;
    logic [NUM_NEURONS-1:0] wr_en_q;
    logic [ADDR_WIDTH-1:0]  wr_addr_q;
    logic [DATA_WIDTH-1:0]  wr_data_q;
    logic                   hs;
    logic                   last_word;

    assign hs        = s_valid & s_ready;
    assign last_word = (nrn_cnt == NRN_LAST) && (w_cnt == W_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (hs && !s_last) begin
                    state_nxt = (s_data[7:0] == LAYER) ? LOAD : SKIP;
                end
            end
            LOAD, SKIP: begin
                if (hs) begin
                    if (last_word) begin
                        state_nxt = DONE;
                    end else if (s_last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            nrn_cnt   <= '0;
            w_cnt     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != DONE);
            wr_en_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (hs) begin
                case (state)
                    IDLE: begin
                        nrn_cnt <= '0;
                        w_cnt   <= '0;
                        err_q   <= s_last;
                    end
                    LOAD, SKIP: begin
                        if (state == LOAD) begin
                            wr_en_q   <= ONE_HOT0 << nrn_cnt;
                            wr_addr_q <= w_cnt;
                            wr_data_q <= s_data;
                        end
                        // Word P must carry s_last; s_last anywhere earlier aborts the packet.
                        if (last_word) begin
                            done_q <= s_last && (state == LOAD);
                            err_q  <= !s_last;
                        end else begin
                            err_q  <= s_last;
                        end
                        if (w_cnt == W_LAST) begin
                            w_cnt   <= '0;
                            nrn_cnt <= nrn_cnt + 1'b1;
                        end else begin
                            w_cnt   <= w_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign s_ready = ready_q;
    assign busy    = (state != IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Bench for weight_load_ctrl: packet-level reference model predicts every write, done, err
// and DONE bubble with its cycle; a negedge monitor logs what the DUT actually does.
module tb_weight_load_ctrl;
    localparam int NN = 2;
    localparam int WN = 3;
    localparam int LN = 1;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int P  = NN * WN;

    // kind: 0 write, 1 done, 2 err, 3 s_ready low
    typedef struct packed {
        logic [31:0]   cyc;
        logic [1:0]    kind;
        logic [NN-1:0] en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic [NN-1:0] wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          err;

    weight_load_ctrl #(
        .NUM_NEURONS(NN), .WEIGHT_NUM(WN), .LAYER_NO(LN), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];
    ev_t act_q[$];
    int  exp_busy = 0;
    int  act_busy = 0;
    bit  mon_rdy = 1'b0;

    // Model: 0 idle, 1 loading this layer, 2 skipping another layer's packet
    int m_st = 0;
    int m_k = 0;
    int m_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int c, input int kind, input logic [NN-1:0] en,
                               input logic [AW-1:0] a, input logic [DW-1:0] dd);
        ev_t e;
        e.cyc  = 32'(c);
        e.kind = 2'(kind);
        e.en   = en;
        e.addr = a;
        e.data = dd;
        return e;
    endfunction

    always @(negedge clk) begin
        if (wr_en != '0) act_q.push_back(mk(cyc, 0, wr_en, wr_addr, wr_data));
        if (done)        act_q.push_back(mk(cyc, 1, '0, '0, '0));
        if (err)         act_q.push_back(mk(cyc, 2, '0, '0, '0));
        if (mon_rdy && !rst && !s_ready) act_q.push_back(mk(cyc, 3, '0, '0, '0));
        if (busy) act_busy++;
    end

    task automatic model_step(input logic [DW-1:0] d, input logic l, input int t);
        if (m_st == 0) begin
            if (l) begin
                exp_q.push_back(mk(t + 1, 2, '0, '0, '0));
            end else begin
                m_st    = (d[7:0] == 8'(LN)) ? 1 : 2;
                m_k     = 0;
                m_start = t + 1;
            end
        end else begin
            if (m_st == 1)
                exp_q.push_back(mk(t + 1, 0, NN'(1 << (m_k / WN)), AW'(m_k % WN), d));
            if (m_k == P - 1) begin
                if (l && m_st == 1) exp_q.push_back(mk(t + 1, 1, '0, '0, '0));
                if (!l)             exp_q.push_back(mk(t + 1, 2, '0, '0, '0));
                exp_q.push_back(mk(t + 1, 3, '0, '0, '0));
                exp_busy += t + 2 - m_start;
                m_st = 0;
            end else if (l) begin
                exp_q.push_back(mk(t + 1, 2, '0, '0, '0));
                exp_busy += t + 1 - m_start;
                m_st = 0;
            end else begin
                m_k++;
            end
        end
    endtask

    // Called right after a posedge (+#1); returns at the same phase one handshake later.
    task automatic send_word(input logic [DW-1:0] d, input logic l, input int gaps);
        bit acc;
        int t;
        int guard;
        repeat (gaps) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        acc     = 1'b0;
        t       = 0;
        guard   = 0;
        while (!acc) begin
            @(negedge clk);
            acc = s_ready;
            t   = cyc;
            @(posedge clk); #1;
            guard++;
            if (!acc && guard > 100) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout: s_ready stayed %b for %0d cycles, required 1", s_ready, guard);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (acc) model_step(d, l, t);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_logs();
        exp_q.delete();
        act_q.delete();
        exp_busy = 0;
        act_busy = 0;
    endtask

    task automatic send_packet(input logic [DW-1:0] hdr, input logic [DW-1:0] base, input int gaps);
        send_word(hdr, 1'b0, 0);
        for (int k = 0; k < P; k++) send_word(base + DW'(k), (k == P - 1), gaps);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mon_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b required 0", s_ready); end
        checks++; if (wr_en !== '0) begin errors++; $display("FAIL reset_wr_en: got %b required 00", wr_en); end
        checks++; if (wr_addr !== '0 || wr_data !== '0) begin errors++; $display("FAIL reset_wr_bus: got %h/%h required 0/0", wr_addr, wr_data); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got busy/done/err %b required 000", {busy, done, err}); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b required 1", s_ready); end
        @(posedge clk); #1;
        m_st = 0;
        mon_rdy = 1'b1;
    endtask

    task automatic test_nominal();
        clear_logs();
        send_packet(16'h0001, 16'h0010, 0);
        idle(4);
        checks++;
        if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL nominal_events: got %0d required %0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL nominal_ev[%0d]: got %h required %h", i, act_q[i], exp_q[i]); end
        end
        checks++; if (act_busy !== exp_busy) begin errors++; $display("FAIL nominal_busy: got %0d cycles required %0d", act_busy, exp_busy); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_fall: got %b required 0", busy); end
    endtask

    task automatic test_layer_filter();
        clear_logs();
        send_packet(16'h0002, 16'h0040, 0);
        idle(4);
        checks++;
        if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL filter_events: got %0d required %0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL filter_ev[%0d]: got %h required %h", i, act_q[i], exp_q[i]); end
        end
        checks++; if (act_busy !== 7) begin errors++; $display("FAIL filter_busy: got %0d cycles required 7", act_busy); end
    endtask

    task automatic test_backpressure();
        clear_logs();
        send_word(16'h0001, 1'b0, 0);
        for (int k = 0; k < P; k++) send_word(16'h0010 + DW'(k), (k == P - 1), 1);
        idle(4);
        checks++;
        if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_events: got %0d required %0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_ev[%0d]: got %h required %h", i, act_q[i], exp_q[i]); end
        end
        checks++; if (act_busy !== exp_busy) begin errors++; $display("FAIL bp_busy: got %0d cycles required %0d", act_busy, exp_busy); end
    endtask

    task automatic test_early_last();
        clear_logs();
        send_word(16'h0001, 1'b0, 0);
        for (int k = 0; k < 4; k++) send_word(16'h0010 + DW'(k), (k == 3), 0);
        idle(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL early_idle: busy got %b required 0", busy); end
        send_packet(16'h0001, 16'h0020, 0);
        idle(4);
        checks++;
        if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL early_events: got %0d required %0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL early_ev[%0d]: got %h required %h", i, act_q[i], exp_q[i]); end
        end
        checks++; if (act_busy !== exp_busy) begin errors++; $display("FAIL early_busy: got %0d cycles required %0d", act_busy, exp_busy); end
    endtask

    task automatic test_missing_last();
        clear_logs();
        send_word(16'h0101, 1'b0, 0);
        for (int k = 0; k < P; k++) send_word(16'h0030 + DW'(k), 1'b0, 0);
        idle(4);
        checks++;
        if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL missing_events: got %0d required %0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL missing_ev[%0d]: got %h required %h", i, act_q[i], exp_q[i]); end
        end
        checks++; if (act_busy !== exp_busy) begin errors++; $display("FAIL missing_busy: got %0d cycles required %0d", act_busy, exp_busy); end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        send_word(16'h0001, 1'b0, 0);
        for (int k = 0; k < 3; k++) send_word(16'h0050 + DW'(k), 1'b0, 0);
        mon_rdy = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (wr_en !== '0) begin errors++; $display("FAIL rstmid_wr_en: got %b required 00", wr_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", busy); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rstmid_s_ready: got %b required 0", s_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after: got %b required 1", s_ready); end
        @(posedge clk); #1;
        m_st = 0;
        mon_rdy = 1'b1;
        exp_busy = 0;
        act_busy = 0;
        send_packet(16'h0001, 16'h0060, 0);
        idle(4);
        checks++;
        if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_events: got %0d required %0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_ev[%0d]: got %h required %h", i, act_q[i], exp_q[i]); end
        end
        checks++; if (act_busy !== exp_busy) begin errors++; $display("FAIL rstmid_busy_cnt: got %0d cycles required %0d", act_busy, exp_busy); end
    endtask

    task automatic test_random();
        int r;
        int mode;
        int cut;
        logic [7:0] layer;
        clear_logs();
        for (int p = 0; p < 20; p++) begin
            r = $urandom_range(99);
            layer = ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'(LN);
            if (r < 8) begin
                send_word({8'($urandom_range(255)), layer}, 1'b1, $urandom_range(2));
                continue;
            end
            mode = $urandom_range(9);
            cut  = (mode == 0) ? $urandom_range(P - 2) : P - 1;
            send_word({8'($urandom_range(255)), layer}, 1'b0, $urandom_range(2));
            for (int k = 0; k <= cut; k++)
                send_word(DW'($urandom), (k == cut) && (mode != 1), $urandom_range(2));
        end
        idle(4);
        checks++;
        if (act_q.size() != exp_q.size()) begin errors++; $display("FAIL random_events: got %0d required %0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_ev[%0d]: got %h required %h", i, act_q[i], exp_q[i]); end
        end
        checks++; if (act_busy !== exp_busy) begin errors++; $display("FAIL random_busy: got %0d cycles required %0d", act_busy, exp_busy); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_layer_filter();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_load_ctrl.md
# weight_load_ctrl

Sequences the runtime (non-pretrained) load of one layer's weight memories. It accepts a valid/ready word stream from the host/config bus and filters it by layer number. Each payload word is steered into the correct neuron's weight memory write port (`wr_en`/`wr_addr`/`wr_data`), neuron by neuron and weight by weight. One instance sits per layer, between the config bus and that layer's bank of weight memories. While a load is in progress it asserts `busy`, and the layer's inference sequencer must keep all weight-memory `rd_en` low.

## Interface
- `NUM_NEURONS`, 30 — neurons (weight memories) in this layer; ≥1
- `WEIGHT_NUM`, 784 — weights per neuron; ≥1, ≤ 2^ADDR_WIDTH
- `LAYER_NO`, 1 — layer number this instance accepts (0..255)
- `ADDR_WIDTH`, 10 — weight memory address width
- `DATA_WIDTH`, 16 — weight width; ≥8
- `clk` in 1 — clock; all logic on rising edge
- `rst` in 1 — synchronous, active-high reset
- `s_valid` in 1 — stream word valid
- `s_ready` out 1 — stream word accepted when `s_valid & s_ready`
- `s_data` in DATA_WIDTH — header or payload word
- `s_last` in 1 — marks final word of a load packet
- `wr_en` out NUM_NEURONS — one-hot write enable, bit n drives neuron n's memory
- `wr_addr` out ADDR_WIDTH — shared write address
- `wr_data` out DATA_WIDTH — shared write data
- `busy` out 1 — high from header accept until packet end
- `done` out 1 — one-cycle pulse: matching layer fully loaded
- `err` out 1 — one-cycle pulse: framing error

## Operation
- Packet format: 1 header word, then exactly P = NUM_NEURONS×WEIGHT_NUM payload words. `s_last` is set only on the final payload word.
- Header: `s_data[7:0]` = target layer; the upper bits are ignored.
- Payload order: neuron 0 weights 0..WEIGHT_NUM-1, then neuron 1, and so on.
- States:
  - IDLE: `s_ready`=1. On a header handshake, go to LOAD if `s_data[7:0]==LAYER_NO`, else SKIP. A header with `s_last`=1 pulses `err` and stays in IDLE.
  - LOAD: `s_ready`=1. Each handshake writes one word. Counters are `nrn_cnt` (0..NUM_NEURONS-1) and `w_cnt` (0..WEIGHT_NUM-1). `w_cnt` wraps to 0 and increments `nrn_cnt` after WEIGHT_NUM-1.
  - SKIP: `s_ready`=1. Words are consumed and counted identically, with no writes.
  - DONE: `s_ready`=0 for one cycle, then go to IDLE.
- End of packet:
  - Handshake on word P with `s_last`=1 goes to DONE; `done` pulses in DONE only if the packet came from LOAD.
  - Handshake on word P with `s_last`=0: the word is still written, then go to DONE with `err` pulsed and `done` suppressed. Stray words after that arrive in IDLE and are treated as headers.
  - `s_last`=1 on payload word k<P: the word is written (LOAD), `err` pulses, and the state goes directly to IDLE. Memory is left partially updated; there is no rollback.
- `busy` = 1 in LOAD, SKIP and DONE.
- Counter widths: `nrn_cnt` uses $clog2(NUM_NEURONS) bits (min 1); `w_cnt` uses ADDR_WIDTH bits. Counters clear on every header accept.
- Mid-packet `rst`: the next state is IDLE, and all outputs and counters are zero. Words already written remain in memory.
- `s_valid` low in any state: the state holds and no write occurs.

## Timing
- Write latency is 1 cycle. A payload handshake in cycle t gives `wr_en[nrn_cnt]`=1, `wr_addr`=`w_cnt`, `wr_data`=`s_data` in cycle t+1 (all registered). The memory captures the data at edge t+2.
- `wr_en` is all-zero in any cycle without a preceding LOAD handshake; at most one bit is set.
- `wr_addr` and `wr_data` hold their last value when `wr_en`=0.
- Full throughput: one word per cycle in LOAD/SKIP. The only bubble is the DONE cycle.
- `done`/`err` are registered and asserted in the DONE cycle or the cycle after the offending handshake; each is exactly 1 cycle wide.
- Reset values: `s_ready`=0 during the reset cycle and 1 in the first cycle after reset. `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `err`=0.

## Test plan
Use NUM_NEURONS=2, WEIGHT_NUM=3, LAYER_NO=1.
- **Nominal load:** header 0x0001, payload 0x10..0x15 back-to-back, last on 0x15. Required: `wr_en`=01 with addr 0,1,2 and data 0x10–0x12; then `wr_en`=10 with addr 0,1,2 and data 0x13–0x15; each write one cycle after its handshake. `done` pulses once, `err`=0, `busy` falls after the DONE cycle.
- **Layer filter:** header 0x0002 plus 6 words. Required: `wr_en` never set, `done`=0, `busy` high for 7 cycles, `s_ready`=0 exactly in DONE.
- **Back-pressure gaps:** nominal packet with `s_valid` toggling 1-0-1. Required: same writes and order as nominal, none on idle cycles, counters stalled.
- **Early `s_last`:** `s_last` set on payload word 4 (0x13). Required: 0x13 written to neuron 1 addr 0, `err` pulses, return to IDLE. The next 0x0001 header starts a fresh load at neuron 0 addr 0.
- **Missing `s_last`:** 6 payload words with no `s_last`. Required: all 6 words written, `err` pulses in DONE, `done`=0.
- **Reset mid-load:** assert `rst` after 3 payload words. Required: next cycle `wr_en`=0, `busy`=0, `s_ready`=0; the following cycle `s_ready`=1. A new full packet then loads correctly from neuron 0 addr 0.
